// File: rtl/rc_filter_pkg.sv
// Shared types and elaboration-time helpers for the multichannel RC filter.
// rc_alpha turns the R/C/rate parameters into the fixed-point update coefficient.
package rc_filter_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PUBLISH} rc_state_t;

  function automatic longint rc_alpha(input longint sample_rate, input longint oversample,
                                      input longint r, input longint c35,
                                      input int alpha_frac, input longint alpha_override);
    longint dt;
    longint rc;
    if (alpha_override != 0) return alpha_override;
    dt = (longint'(1) <<< 32) / (sample_rate * oversample);
    rc = (r * c35) >>> 3;
    return (dt <<< alpha_frac) / (rc + dt);
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/rc_filter_step.sv
// One RC sub-step: y_next = sat(y + floor(alpha * (x - y) / 2^ALPHA_FRAC)).
// Purely combinational; the top shares a single instance across all channels.
module rc_filter_step
  import rc_filter_pkg::*;
#(
  parameter int     DATA_WIDTH = 16,
  parameter int     ALPHA_FRAC = 16,
  parameter longint ALPHA      = 154
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [DATA_WIDTH-1:0] y,
  output logic signed [DATA_WIDTH-1:0] y_next
);

  // Product needs DATA_WIDTH+1 bits of difference times ALPHA_FRAC+1 bits of alpha.
  localparam int PW = DATA_WIDTH + ALPHA_FRAC + 2;
  localparam logic signed [PW-1:0] ALPHA_EXT = PW'(ALPHA);

  logic signed [DATA_WIDTH:0] d;
  logic signed [PW-1:0]       d_ext;
  logic signed [PW-1:0]       p;
  logic signed [PW-1:0]       t;
  logic signed [63:0]         sum;

  assign d      = {x[DATA_WIDTH-1], x} - {y[DATA_WIDTH-1], y};
  assign d_ext  = {{(PW-DATA_WIDTH-1){d[DATA_WIDTH]}}, d};
  assign p      = d_ext * ALPHA_EXT;
  assign t      = p >>> ALPHA_FRAC;
  assign sum    = {{(64-PW){t[PW-1]}}, t} + {{(64-DATA_WIDTH){y[DATA_WIDTH-1]}}, y};
  assign y_next = DATA_WIDTH'(sat(sum, DATA_WIDTH));

endmodule

// File: rtl/rc_filter_multichannel.sv
// Time-multiplexed N-channel first-order RC filter with runtime LP/HP select.
// A sample tick latches all channels, then OVERSAMPLE*CHANNELS serial updates run before publish.
module rc_filter_multichannel
  import rc_filter_pkg::*;
#(
  parameter int     CLOCK_RATE     = 50000000,
  parameter int     SAMPLE_RATE    = 48000,
  parameter int     CHANNELS       = 2,
  parameter int     DATA_WIDTH     = 16,
  parameter int     OVERSAMPLE     = 4,
  parameter int     R              = 47000,
  parameter int     C_35_SHIFTED   = 1615,
  parameter int     ALPHA_FRAC     = 16,
  parameter longint ALPHA_OVERRIDE = 0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           audio_clk_en,
  input  logic [CHANNELS-1:0]            mode_hp,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in,
  output logic [CHANNELS*DATA_WIDTH-1:0] out,
  output logic                           out_valid,
  output logic                           busy,
  output logic                           overrun
);

  localparam longint ALPHA = rc_alpha(longint'(SAMPLE_RATE), longint'(OVERSAMPLE), longint'(R),
                                      longint'(C_35_SHIFTED), ALPHA_FRAC, ALPHA_OVERRIDE);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

  if (CHANNELS * OVERSAMPLE + 2 > CLOCK_RATE / SAMPLE_RATE) begin : g_bad_rate
    $error("rc_filter_multichannel: not enough clocks per sample for all sub-steps");
  end
  if (ALPHA <= 0 || ALPHA >= (longint'(1) <<< ALPHA_FRAC)) begin : g_bad_alpha
    $error("rc_filter_multichannel: alpha out of range (0, 1)");
  end

  rc_state_t                    state_q, state_d;
  logic [CW-1:0]                ch_q, ch_d;
  logic [SW-1:0]                sub_q, sub_d;
  logic signed [DATA_WIDTH-1:0] x_q [CHANNELS];
  logic signed [DATA_WIDTH-1:0] y_q [CHANNELS];
  logic [CHANNELS-1:0]          hp_q;
  logic [CHANNELS*DATA_WIDTH-1:0] out_q, out_d;
  logic                         overrun_q;
  logic signed [DATA_WIDTH-1:0] x_sel, y_sel, y_upd;
  logic                         last_ch, last_sub, last_update;

  assign x_sel       = x_q[ch_q];
  assign y_sel       = y_q[ch_q];
  assign last_ch     = (ch_q == CW'(CHANNELS - 1));
  assign last_sub    = (sub_q == SW'(OVERSAMPLE - 1));
  assign last_update = (state_q == RUN) && last_ch && last_sub;

  rc_filter_step #(
    .DATA_WIDTH(DATA_WIDTH),
    .ALPHA_FRAC(ALPHA_FRAC),
    .ALPHA     (ALPHA)
  ) u_step (
    .x     (x_sel),
    .y     (y_sel),
    .y_next(y_upd)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    sub_d   = sub_q;
    case (state_q)
      IDLE: begin
        if (audio_clk_en) begin
          state_d = RUN;
          ch_d    = '0;
          sub_d   = '0;
        end
      end
      RUN: begin
        if (last_ch) begin
          ch_d = '0;
          if (last_sub) state_d = PUBLISH;
          else          sub_d   = sub_q + SW'(1);
        end else begin
          ch_d = ch_q + CW'(1);
        end
      end
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output word is captured on the last update edge, so the final channel bypasses its y register.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_pub
    logic signed [DATA_WIDTH-1:0] y_pub;
    logic signed [63:0]           diff;
    assign y_pub = (ch_q == CW'(gi)) ? y_upd : y_q[gi];
    assign diff  = {{(64-DATA_WIDTH){x_q[gi][DATA_WIDTH-1]}}, x_q[gi]}
                 - {{(64-DATA_WIDTH){y_pub[DATA_WIDTH-1]}}, y_pub};
    assign out_d[gi*DATA_WIDTH +: DATA_WIDTH] = hp_q[gi] ? DATA_WIDTH'(sat(diff, DATA_WIDTH)) : y_pub;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      sub_q     <= '0;
      hp_q      <= '0;
      out_q     <= '0;
      overrun_q <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      sub_q   <= sub_d;
      if (audio_clk_en && state_q != IDLE) overrun_q <= 1'b1;
      if (audio_clk_en && state_q == IDLE) begin
        hp_q <= mode_hp;
        for (int k = 0; k < CHANNELS; k++) x_q[k] <= in[k*DATA_WIDTH +: DATA_WIDTH];
      end
      if (state_q == RUN) y_q[ch_q] <= y_upd;
      if (last_update) out_q <= out_d;
    end
  end

  assign out       = out_q;
  assign out_valid = (state_q == PUBLISH);
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_rc_filter_multichannel.sv
// Bench: two single-channel instances (alpha 1/2 and ~1) driven from a vector table,
// plus a 4-channel default instance checked against an arithmetic reference model.
module tb_rc_filter_multichannel;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int NO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic tick_a, tick_b, tick_c;
  logic [0:0] hp_a, hp_b;
  logic [NC-1:0] hp_c;
  logic [DW-1:0] in_a, in_b, out_a, out_b;
  logic [NC*DW-1:0] in_c, out_c;
  logic ov_a, ov_b, ov_c, busy_a, busy_b, busy_c, orun_a, orun_b, orun_c;

  rc_filter_multichannel #(.CHANNELS(1), .OVERSAMPLE(1), .ALPHA_OVERRIDE(32768)) u_a (
    .clk(clk), .reset_n(reset_n), .audio_clk_en(tick_a), .mode_hp(hp_a), .in(in_a),
    .out(out_a), .out_valid(ov_a), .busy(busy_a), .overrun(orun_a));
  rc_filter_multichannel #(.CHANNELS(1), .OVERSAMPLE(1), .ALPHA_OVERRIDE(65535)) u_b (
    .clk(clk), .reset_n(reset_n), .audio_clk_en(tick_b), .mode_hp(hp_b), .in(in_b),
    .out(out_b), .out_valid(ov_b), .busy(busy_b), .overrun(orun_b));
  rc_filter_multichannel #(.CHANNELS(NC), .OVERSAMPLE(NO)) u_c (
    .clk(clk), .reset_n(reset_n), .audio_clk_en(tick_c), .mode_hp(hp_c), .in(in_c),
    .out(out_c), .out_valid(ov_c), .busy(busy_c), .overrun(orun_c));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model for the 4-channel instance ----------------
  longint alpha_m;
  longint ym [NC];
  longint expo [NC];

  function automatic longint floor_div(input longint p, input longint q);
    longint r;
    r = p / q;
    if ((p % q) != 0 && p < 0) r = r - 1;
    return r;
  endfunction

  function automatic longint clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_sample(input longint xs [NC], input logic [NC-1:0] hps);
    for (int s = 0; s < NO; s++)
      for (int k = 0; k < NC; k++)
        ym[k] = clamp16(ym[k] + floor_div(alpha_m * (xs[k] - ym[k]), 65536));
    for (int k = 0; k < NC; k++)
      expo[k] = hps[k] ? clamp16(xs[k] - ym[k]) : ym[k];
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) ym[k] = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // ---------------- single-channel sample runner ----------------
  task automatic run_ab(input int sel, input int x, input logic hp, output longint o, output int lat);
    @(negedge clk);
    if (sel == 0) begin in_a = x[15:0]; hp_a = hp; tick_a = 1'b1; end
    else          begin in_b = x[15:0]; hp_b = hp; tick_b = 1'b1; end
    lat = 0;
    o = 99999;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      tick_a = 1'b0;
      tick_b = 1'b0;
      lat++;
      if ((sel == 0) ? ov_a : ov_b) begin
        o = (sel == 0) ? longint'($signed(out_a)) : longint'($signed(out_b));
        break;
      end
    end
  endtask

  // ---------------- 4-channel sample runner ----------------
  task automatic run_c(input longint xs [NC], input logic [NC-1:0] hps, input string tag);
    int lat;
    bit seen;
    @(negedge clk);
    for (int k = 0; k < NC; k++) in_c[k*DW +: DW] = xs[k][15:0];
    hp_c = hps;
    tick_c = 1'b1;
    lat = 0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      tick_c = 1'b0;
      lat++;
      if (ov_c) seen = 1;
    end
    model_sample(xs, hps);
    check({tag, "_latency"}, lat, NC * NO + 1);
    for (int k = 0; k < NC; k++)
      check($sformatf("%s_ch%0d", tag, k), longint'($signed(out_c[k*DW +: DW])), expo[k]);
  endtask

  typedef struct {
    bit     rst;
    int     sel;
    int     x;
    bit     hp;
    longint exp;
  } vec_t;

  vec_t vecs [$];
  longint xs [NC];
  longint o;
  int lat;
  int pulses;

  initial begin
    reset_n = 1'b0;
    tick_a = 0; tick_b = 0; tick_c = 0;
    hp_a = 0; hp_b = 0; hp_c = '0;
    in_a = '0; in_b = '0; in_c = '0;
    alpha_m = ((longint'(1) << 32) / (48000 * NO) * 65536)
            / ((longint'(47000) * 1615) / 8 + (longint'(1) << 32) / (48000 * NO));
    model_reset();

    repeat (2) @(negedge clk);
    check("reset_busy", {busy_a, busy_b, busy_c}, 0);
    check("reset_valid", {ov_a, ov_b, ov_c}, 0);
    check("reset_overrun", {orun_a, orun_b, orun_c}, 0);
    check("reset_out_c", longint'(out_c), 0);
    check("reset_out_ab", longint'({out_a, out_b}), 0);
    reset_n = 1'b1;

    // alpha 1/2 step and high-pass, then alpha 65535/65536 saturation and floor
    vecs.push_back('{1, 0, 16384, 0, 8192});
    vecs.push_back('{0, 0, 16384, 0, 12288});
    vecs.push_back('{0, 0, 16384, 0, 14336});
    vecs.push_back('{0, 0, 16384, 0, 15360});
    vecs.push_back('{1, 0, 16384, 1, 8192});
    vecs.push_back('{0, 0, 16384, 1, 4096});
    vecs.push_back('{0, 0, 16384, 1, 2048});
    vecs.push_back('{0, 0, 16384, 1, 1024});
    vecs.push_back('{1, 1, 32767, 0, 32766});
    vecs.push_back('{0, 1, 32767, 0, 32766});
    vecs.push_back('{0, 1, -32768, 0, -32768});
    vecs.push_back('{0, 1, 32767, 1, 1});
    vecs.push_back('{0, 1, -32768, 1, 0});
    vecs.push_back('{0, 1, -3, 0, -4});
    vecs.push_back('{0, 1, 0, 0, -1});
    vecs.push_back('{0, 1, -3, 0, -3});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) pulse_reset();
      run_ab(vecs[i].sel, vecs[i].x, vecs[i].hp, o, lat);
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_out", i), o, vecs[i].exp);
      $display("vec %0d: dut=%0d x=%0d hp=%0d out=%0d", i, vecs[i].sel, vecs[i].x, vecs[i].hp, o);
    end

    // 4-channel constant inputs 1000*k
    pulse_reset();
    for (int k = 0; k < NC; k++) xs[k] = 1000 * k;
    for (int n = 0; n < 3; n++) begin
      run_c(xs, 4'b0000, $sformatf("const%0d", n));
      $display("const sample %0d: out=%h", n, out_c);
    end
    check("no_overrun_yet", orun_c, 0);

    // randomized full-range samples with random HP select and idle gaps
    for (int n = 0; n < 12; n++) begin
      for (int k = 0; k < NC; k++) xs[k] = longint'($signed(16'($urandom)));
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_c(xs, 4'($urandom), $sformatf("rand%0d", n));
      $display("rand sample %0d: in=%h hp=%b out=%h", n, in_c, hp_c, out_c);
    end

    // high-pass saturation: y driven positive, then x at negative full scale
    pulse_reset();
    for (int k = 0; k < NC; k++) xs[k] = 32767;
    run_c(xs, 4'b0000, "hpsat_a");
    run_c(xs, 4'b0000, "hpsat_b");
    for (int k = 0; k < NC; k++) xs[k] = -32768;
    run_c(xs, 4'b1111, "hpsat_c");
    check("hpsat_clamp", longint'($signed(out_c[DW-1:0])), -32768);
    $display("hp saturation: out=%h", out_c);

    // overrun: second tick 3 clocks after the first, with different data
    @(negedge clk);
    for (int k = 0; k < NC; k++) begin xs[k] = 500 + 300 * k; in_c[k*DW +: DW] = xs[k][15:0]; end
    hp_c = 4'b0101;
    tick_c = 1'b1;
    @(negedge clk); tick_c = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_c = {4{16'h7000}};
    hp_c = 4'b1010;
    tick_c = 1'b1;
    @(negedge clk); tick_c = 1'b0;
    check("overrun_set", orun_c, 1);
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      if (ov_c) begin
        pulses++;
        if (pulses == 1) o = longint'(out_c);
      end
      @(negedge clk);
    end
    check("overrun_pulses", pulses, 1);
    model_sample(xs, 4'b0101);
    for (int k = 0; k < NC; k++)
      check($sformatf("overrun_ch%0d", k), longint'($signed(o[k*DW +: DW])), expo[k]);
    for (int k = 0; k < NC; k++) xs[k] = -2000 * k;
    run_c(xs, 4'b0011, "after_overrun");
    check("overrun_sticky", orun_c, 1);
    $display("overrun test: pulses=%0d overrun=%0d", pulses, orun_c);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    tick_c = 1'b1;
    @(negedge clk); tick_c = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun_busy_before", busy_c, 1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrun_busy", busy_c, 0);
    check("midrun_out", longint'(out_c), 0);
    check("midrun_valid", ov_c, 0);
    check("midrun_overrun", orun_c, 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int k = 0; k < NC; k++) xs[k] = 1000 * k;
    run_c(xs, 4'b0000, "post_reset");
    $display("post reset sample: out=%h", out_c);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
